// File: rtl/qq_pkg.sv
// Shared types and constants for the QuickQ host front end (qq_host_if, qq_cmd_fifo).
package qq_pkg;

    localparam int unsigned CMD_DATA_W = 32;
    localparam logic [31:0] EMPTY_VAL  = 32'hFFFF_FFFF;
    localparam logic [31:0] ERROR_VAL  = 32'h0000_0000;

    typedef enum logic {
        OP_ENQ = 1'b0,
        OP_DEQ = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DEQ,
        RESP
    } state_t;

    typedef struct packed {
        op_t                   op;
        logic [CMD_DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/qq_cmd_fifo.sv
// Synchronous command FIFO of cmd_t; head is read straight from the storage registers.
module qq_cmd_fifo
    import qq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset_i,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output cmd_t head
);

    localparam int unsigned AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/qq_host_if.sv
// Host-side front end for the QuickQ chain: buffers ENQ/DEQ commands, paces chain pulses,
// tracks occupancy and returns one response per command. Optional counters: QQ_STATS_EN.
module qq_host_if
    import qq_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CAPACITY  = 8,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned ISSUE_GAP = 3,
    parameter int unsigned DEQ_LAT   = 2
) (
    input  logic                           clk,
    input  logic                           reset_i,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  op_t                            cmd_op_i,
    input  logic [DATA_W-1:0]              cmd_data_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DATA_W-1:0]              rsp_data_o,
    output logic                           rsp_err_o,
    output logic [DATA_W-1:0]              q_data_o,
    output logic                           q_write_o,
    output logic                           q_read_o,
    output logic                           q_reset_o,
    input  logic [DATA_W-1:0]              q_data_i,
    output logic [$clog2(CAPACITY+1)-1:0]  count_o,
    output logic                           full_o,
    output logic                           empty_o
`ifdef QQ_STATS_EN
    ,
    output logic [15:0]                    stat_enq_o,
    output logic [15:0]                    stat_deq_o,
    output logic [15:0]                    stat_err_o
`endif
);

    localparam int unsigned CNT_W = $clog2(CAPACITY + 1);
    localparam int unsigned GAP_W = $clog2(ISSUE_GAP + 1);
    localparam int unsigned LAT_W = $clog2(DEQ_LAT + 1);

    state_t              state, state_n;
    op_t                 cur_op, cur_op_n;
    logic [CNT_W-1:0]    count, count_n;
    logic [GAP_W-1:0]    gap, gap_n;
    logic [LAT_W-1:0]    lat, lat_n;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_n;
    logic                rsp_err_q, rsp_err_n;
    logic [DATA_W-1:0]   q_data_q, q_data_n;
    logic                q_reset_q;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    cmd_t                push_cmd, head;

    assign cmd_ready_o = !fifo_full && !reset_i;
    assign fifo_push   = cmd_valid_i && cmd_ready_o;
    assign push_cmd    = '{op: cmd_op_i, data: CMD_DATA_W'(cmd_data_i)};

    qq_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .reset_i   (reset_i),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    always_ff @(posedge clk) begin
        q_reset_q <= reset_i;
        if (reset_i) begin
            state      <= IDLE;
            cur_op     <= OP_ENQ;
            count      <= '0;
            gap        <= '0;
            lat        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            q_data_q   <= '0;
        end else begin
            state      <= state_n;
            cur_op     <= cur_op_n;
            count      <= count_n;
            gap        <= gap_n;
            lat        <= lat_n;
            rsp_data_q <= rsp_data_n;
            rsp_err_q  <= rsp_err_n;
            q_data_q   <= q_data_n;
        end
    end

    always_comb begin
        state_n    = state;
        cur_op_n   = cur_op;
        count_n    = count;
        gap_n      = (gap != '0) ? gap - 1'b1 : gap;
        lat_n      = lat;
        rsp_data_n = rsp_data_q;
        rsp_err_n  = rsp_err_q;
        q_data_n   = q_data_q;
        fifo_pop   = 1'b0;

        unique case (state)
            IDLE: begin
                if (!fifo_empty && gap == '0) begin
                    fifo_pop = 1'b1;
                    cur_op_n = head.op;
                    if (head.op == OP_ENQ && count == CNT_W'(CAPACITY)) begin
                        rsp_err_n  = 1'b1;
                        rsp_data_n = DATA_W'(ERROR_VAL);
                        state_n    = RESP;
                    end else if (head.op == OP_DEQ && count == '0) begin
                        rsp_err_n  = 1'b1;
                        rsp_data_n = DATA_W'(EMPTY_VAL);
                        state_n    = RESP;
                    end else begin
                        // Gap is loaded on entry so the pulse cycle itself counts toward spacing.
                        rsp_err_n = 1'b0;
                        gap_n     = GAP_W'(ISSUE_GAP - 1);
                        state_n   = ISSUE;
                        if (head.op == OP_ENQ) begin
                            q_data_n   = DATA_W'(head.data);
                            rsp_data_n = DATA_W'(head.data);
                        end
                    end
                end
            end
            ISSUE: begin
                if (cur_op == OP_ENQ) begin
                    count_n = count + 1'b1;
                    state_n = RESP;
                end else begin
                    count_n = count - 1'b1;
                    lat_n   = LAT_W'(DEQ_LAT - 1);
                    state_n = WAIT_DEQ;
                end
            end
            WAIT_DEQ: begin
                if (lat == '0) begin
                    rsp_data_n = q_data_i;
                    state_n    = RESP;
                end else begin
                    lat_n = lat - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rsp_valid_o = (state == RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign q_data_o    = q_data_q;
    assign q_write_o   = (state == ISSUE) && (cur_op == OP_ENQ);
    assign q_read_o    = (state == ISSUE) && (cur_op == OP_DEQ);
    assign q_reset_o   = q_reset_q;
    assign count_o     = count;
    assign full_o      = (count == CNT_W'(CAPACITY));
    assign empty_o     = (count == '0);

`ifdef QQ_STATS_EN
    logic [15:0] stat_enq, stat_deq, stat_err;
    logic        err_hit;

    assign err_hit = (state == IDLE) && (state_n == RESP);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            stat_enq <= '0;
            stat_deq <= '0;
            stat_err <= '0;
        end else begin
            if (q_write_o && stat_enq != '1) begin
                stat_enq <= stat_enq + 16'd1;
            end
            if (q_read_o && stat_deq != '1) begin
                stat_deq <= stat_deq + 16'd1;
            end
            if (err_hit && stat_err != '1) begin
                stat_err <= stat_err + 16'd1;
            end
        end
    end

    assign stat_enq_o = stat_enq;
    assign stat_deq_o = stat_deq;
    assign stat_err_o = stat_err;
`endif

endmodule
